// File: rtl/div_rep_sub_pkg.sv
// Shared constants for the repeated-subtraction divider: default operand width
// and the 2-bit binary FSM state encodings.
package div_rep_sub_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/div_rep_sub_datapath.sv
// Divider datapath: remainder, quotient and divisor registers with the
// subtractor, incrementer and comparator, steered by strobes from the FSM.
module div_rep_sub_datapath
  import div_rep_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ld,
  input  logic             i_sub_en,
  input  logic             i_set_dbz,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_geq,
  output logic             o_bz,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_b;
  logic             r_dbz;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_inc;

  // The subtract only commits when o_geq is true, so it never wraps.
  assign w_diff = r_rem - r_b;
  assign w_inc  = r_quot + ONE;
  assign o_geq  = (r_rem >= r_b);
  assign o_bz   = (r_b == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_b    <= '0;
      r_dbz  <= 1'b0;
    end else if (i_ld) begin
      r_rem  <= i_dividend;
      r_quot <= '0;
      r_b    <= i_divisor;
      r_dbz  <= 1'b0;
    end else if (i_set_dbz) begin
      r_quot <= '1;
      r_dbz  <= 1'b1;
    end else if (i_sub_en) begin
      r_rem  <= w_diff;
      r_quot <= w_inc;
    end
  end

  assign o_quotient    = r_quot;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dbz;

endmodule

// File: rtl/div_rep_sub.sv
// Unsigned divider by repeated subtraction: FSM control around the datapath,
// start-pulse in, one-cycle done pulse out.
module div_rep_sub
  import div_rep_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  state_t r_state;
  state_t w_next;
  logic   w_geq;
  logic   w_bz;
  logic   w_ld;
  logic   w_sub_en;
  logic   w_set_dbz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // A zero divisor takes priority over the compare so RUN exits immediately.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN:     if (w_bz || !w_geq) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_ld      = (r_state == LOAD);
  assign w_set_dbz = (r_state == RUN) && w_bz;
  assign w_sub_en  = (r_state == RUN) && !w_bz && w_geq;

  assign o_busy = (r_state == LOAD) || (r_state == RUN);
  assign o_done = (r_state == DONE);

  div_rep_sub_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ld         (w_ld),
    .i_sub_en     (w_sub_en),
    .i_set_dbz    (w_set_dbz),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_geq        (w_geq),
    .o_bz         (w_bz),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_div_by_zero(o_div_by_zero)
  );

endmodule

// File: tb/tb_div_rep_sub.sv
// Self-checking bench for div_rep_sub: expected results are queued as each
// operation is launched and compared when done pulses.
module tb_div_rep_sub;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         dbz;
    int           doneCycle;
  } expect_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divByZero;

  expect_t sbQueue[$];
  int      cycleCount;
  int      errorCount;
  int      checkCount;

  div_rep_sub #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_busy       (busy),
    .o_done       (done),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_div_by_zero(divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checkOutput("busyWithDone", {31'd0, busy}, 32'd0);
      if (sbQueue.size() == 0) begin
        checkOutput("sbEmpty", 32'd1, 32'd0);
      end else begin
        expect_t e;
        e = sbQueue.pop_front();
        checkOutput("quotient", {16'd0, quotient}, {16'd0, e.quot});
        checkOutput("remainder", {16'd0, remainder}, {16'd0, e.rem});
        checkOutput("divByZero", {31'd0, divByZero}, {31'd0, e.dbz});
        checkOutput("latency", cycleCount, e.doneCycle);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    expect_t e;
    int q;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (b == 0) begin
      e.quot = '1;
      e.rem  = a;
      e.dbz  = 1'b1;
      q      = 0;
    end else begin
      e.quot = a / b;
      e.rem  = a % b;
      e.dbz  = 1'b0;
      q      = int'(a / b);
    end
    e.doneCycle = cycleCount + q + 3;
    sbQueue.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int bound);
    int busyLow;
    int n;
    busyLow = 0;
    n = 0;
    while (!done && n < bound) begin
      if (!busy) busyLow++;
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    checkOutput({tag, "_busyHeld"}, busyLow, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;
    #12;
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstQuot", {16'd0, quotient}, 32'd0);
    checkOutput("rstRem", {16'd0, remainder}, 32'd0);
    checkOutput("rstDbz", {31'd0, divByZero}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(16'd17, 16'd5);
    waitDone("d17_5", 50);
    @(negedge clk);
    checkOutput("holdQuot", {16'd0, quotient}, 32'd3);
    checkOutput("holdRem", {16'd0, remainder}, 32'd2);

    applyStimulus(16'd4, 16'd9);
    waitDone("d4_9", 50);

    applyStimulus(16'd100, 16'd0);
    waitDone("d100_0", 50);
    checkOutput("dbzHeld", {31'd0, divByZero}, 32'd1);

    applyStimulus(16'd10, 16'd10);
    waitDone("d10_10", 50);

    applyStimulus(16'hFFFF, 16'd1);
    waitDone("dFFFF_1", 70000);

    // Second start and dividend change during RUN must not disturb the operation.
    applyStimulus(16'd50, 16'd7);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone("d50_7", 50);
    repeat (3) @(negedge clk);
    checkOutput("noQueuedStart", {31'd0, busy}, 32'd0);

    applyStimulus(16'd200, 16'd3);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
    checkOutput("midRstDone", {31'd0, done}, 32'd0);
    checkOutput("midRstQuot", {16'd0, quotient}, 32'd0);
    checkOutput("midRstRem", {16'd0, remainder}, 32'd0);
    checkOutput("midRstDbz", {31'd0, divByZero}, 32'd0);
    sbQueue.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("postRstIdle", {31'd0, busy}, 32'd0);

    applyStimulus(16'd9, 16'd3);
    waitDone("d9_3", 50);

    checkOutput("sbDrained", sbQueue.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/div_rep_sub.md
Name: div_rep_sub

Overview:
- Unsigned integer divider using repeated subtraction; the inverse of the team's repeated-addition multiplier.
- FSM control plus register/subtract/compare datapath.
- Handshake: single-cycle start pulse in, single-cycle done pulse out.
- Sits beside the multiplier as a small-area arithmetic unit for low-rate compute paths.

Parameters:
- WIDTH, 16, bit width of dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured in LOAD.
- divisor  input  WIDTH  denominator; captured in LOAD.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  quotient register.
- remainder  output  WIDTH  remainder register.
- div_by_zero  output  1  set with done when divisor was 0; held until next LOAD.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following, regardless of state (including mid-RUN):
  - state=IDLE
  - busy=0, done=0, div_by_zero=0
  - quotient=0, remainder=0
- States: IDLE, LOAD, RUN, DONE. Binary encoding, 2 bits.
- IDLE: if start=1 -> LOAD; else stay. Outputs hold the last results.
- LOAD (1 cycle):
  - remainder<=dividend, quotient<=0, internal divisor register B<=divisor, div_by_zero<=0.
  - -> RUN.
- RUN (evaluated each cycle, in this priority order):
  - if B==0: div_by_zero<=1, quotient<=all ones, remainder unchanged (=dividend); -> DONE.
  - else if remainder>=B: remainder<=remainder-B, quotient<=quotient+1; stay in RUN.
  - else -> DONE.
- DONE (1 cycle): done=1; -> IDLE.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0+q+2, where q is the final quotient. Divide-by-zero counts as q=0.
- busy=1 exactly while in LOAD or RUN. done and busy are never both high.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE.
- Arithmetic:
  - Compare is an unsigned WIDTH-bit >=.
  - Subtract cannot underflow because it is guarded by the compare.
  - Quotient cannot overflow because q<=dividend<=2^WIDTH-1. No carry out is required.
- dividend/divisor are only sampled in LOAD; changes afterwards have no effect.
- quotient/remainder are the working registers; they are valid only while done=1 and through the following IDLE.
- done, busy and div_by_zero are registered or decoded from registered state only; no combinational path from start.

Decomposition:
- Package div_rep_sub_pkg holds:
  - the state typedef and encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3);
  - the default WIDTH constant.
- One natural sub-module, div_rep_sub_datapath:
  - contains the remainder, quotient and B registers, the subtractor, the incrementer and the comparator;
  - takes control inputs ld, sub_en, set_dbz;
  - provides status outputs geq and bz.
- The top level holds the FSM and drives the datapath control strobes (control/datapath split, as in the multiplier).

Test Plan:
- dividend=17, divisor=5, start pulse -> done after E0+5 edges, quotient=3, remainder=2, div_by_zero=0.
- dividend=4, divisor=9 -> q=0 path, done after E0+2 edges, quotient=0, remainder=4.
- dividend=100, divisor=0 -> done after E0+2 edges, div_by_zero=1, quotient=16'hFFFF, remainder=100. A following 10/10 run gives quotient=1, remainder=0, div_by_zero=0.
- dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0, done after E0+65537 edges; busy stays high throughout.
- Start 50/7. Pulse start again and change the dividend to 3 during RUN -> second start ignored, result quotient=7, remainder=1.
- Start 200/3. Assert rst_n=0 mid-RUN -> all outputs 0 immediately, state IDLE. After release, 9/3 gives quotient=3, remainder=0.
